ym2149_bus_responder: RTL

//  PSG-side end of the AY/YM bus driven by the CPU-side BDIR/BC1 decoder. It decodes

---
 rtl/ym2149_bus_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ym2149_bus_responder.sv
// PSG-side bus responder: synchronizes and glitch-filters the BDIR/BC1 bus,
// latches the register address and serves writes/reads of the 16x8 register file.
module ym2149_bus_responder #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         STABLE_CYCLES = 2,
  parameter logic [3:0] ADDR_HI       = 4'h0
) (
  input  logic           cpu_clock,
  input  logic           reset,
  input  logic           bdir,
  input  logic           bc1,
  input  logic           sel,
  input  logic [7:0]     da_in,
  output logic [7:0]     da_out,
  output logic           da_oe,
  output logic [3:0]     reg_addr,
  output logic           addr_valid,
  output logic           reg_wr,
  output logic [7:0]     reg_wr_data,
  output logic           env_restart,
  output logic [127:0]   regs
);

  // State encoding equals the bus code it represents, so the state is the filtered code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_ADDR  = 2'b11
  } state_t;

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);

  // Per-register implemented-bit masks of the PSG.
  function automatic logic [7:0] reg_mask(input logic [3:0] n);
    case (n)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  // {sel, bdir, bc1, da_in} travel together so code and data stay aligned.
  logic [10:0]   sync_q [SYNC_STAGES];
  logic          s_sel;
  logic [1:0]    s_code;
  logic [7:0]    s_data;
  logic [1:0]    code_s;

  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;

  logic [7:0]    data_q, data_d;
  logic [3:0]    reg_addr_q, reg_addr_d;
  logic          addr_valid_q, addr_valid_d;
  logic          reg_wr_q, reg_wr_d;
  logic [7:0]    reg_wr_data_q, reg_wr_data_d;
  logic          env_restart_q, env_restart_d;
  logic          da_oe_q, da_oe_d;
  logic [7:0]    da_out_q, da_out_d;

  logic [7:0]    regs_q [16];
  logic          wr_en;
  logic [7:0]    wr_val;

  assign s_sel  = sync_q[SYNC_STAGES-1][10];
  assign s_code = sync_q[SYNC_STAGES-1][9:8];
  assign s_data = sync_q[SYNC_STAGES-1][7:0];
  // A deselected chip sees every code as INACTIVE.
  assign code_s = s_sel ? s_code : 2'b00;

  // Synchronizer chain for the asynchronous bus inputs.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      sync_q[0] <= {sel, bdir, bc1, da_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Glitch filter and next state: a code is accepted after STABLE_CYCLES equal samples.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    cand_d  = code_s;
    cnt_d   = CW'(1);
    state_d = state_q;
    if (code_s == cand_q) cnt_d = (cnt_q == STABLE_C) ? cnt_q : cnt_q + 1'b1;
    if (cnt_d == STABLE_C) state_d = state_t'(code_s);
  end

  // Data capture, commit-on-exit actions and read-back path.
  always_comb begin
    data_d        = data_q;
    reg_addr_d    = reg_addr_q;
    addr_valid_d  = addr_valid_q;
    reg_wr_d      = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    env_restart_d = 1'b0;
    wr_en         = 1'b0;
    wr_val        = data_q & reg_mask(reg_addr_q);

    // Capture only samples that still carry this state's own code, so the data
    // that arrives alongside the next code cannot leak into the commit.
    if ((state_d == ST_ADDR || state_d == ST_WRITE) && state_t'(code_s) == state_d)
      data_d = s_data;

    if (state_d != state_q) begin
      case (state_q)
        ST_ADDR: begin
          reg_addr_d   = data_q[3:0];
          addr_valid_d = (data_q[7:4] == ADDR_HI);
        end
        ST_WRITE: begin
          if (addr_valid_q) begin
            wr_en         = 1'b1;
            reg_wr_d      = 1'b1;
            reg_wr_data_d = wr_val;
            env_restart_d = (reg_addr_q == 4'd13);
          end
        end
        default: ;
      endcase
    end

    da_oe_d  = (state_q == ST_READ) && addr_valid_q;
    da_out_d = da_oe_d ? regs_q[reg_addr_q] : 8'h00;
  end

  // Filter, FSM and output registers.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      cand_q        <= 2'b00;
      cnt_q         <= STABLE_C;
      state_q       <= ST_IDLE;
      data_q        <= 8'h00;
      reg_addr_q    <= 4'h0;
      addr_valid_q  <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wr_data_q <= 8'h00;
      env_restart_q <= 1'b0;
      da_oe_q       <= 1'b0;
      da_out_q      <= 8'h00;
    end else begin
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      data_q        <= data_d;
      reg_addr_q    <= reg_addr_d;
      addr_valid_q  <= addr_valid_d;
      reg_wr_q      <= reg_wr_d;
      reg_wr_data_q <= reg_wr_data_d;
      env_restart_q <= env_restart_d;
      da_oe_q       <= da_oe_d;
      da_out_q      <= da_out_d;
    end
  end

  // Register file write port.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      // NOTE: this file is small and its power-on contents are visible to the PSG core,
      // so it is reset as flops rather than left as an unreset RAM.
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else if (wr_en) begin
      regs_q[reg_addr_q] <= wr_val;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_regs
    assign regs[8*g +: 8] = regs_q[g];
  end

  assign da_out      = da_out_q;
  assign da_oe       = da_oe_q;
  assign reg_addr    = reg_addr_q;
  assign addr_valid  = addr_valid_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign env_restart = env_restart_q;

endmodule
